// File: rtl/core_mem_pkg.sv
// core_mem_pkg: shared encodings and widths for the MEM-stage load/store unit.
package core_mem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int LANES  = DATA_W / 8;

    // Access size as presented by the decode stage; 2'b11 behaves as a word.
    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_WORD     = 2'b10,
        SIZE_WORD_ALT = 2'b11
    } mem_size_e;

    // Access sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    // Byte-enable patterns before lane shifting.
    localparam logic [LANES-1:0] BE_BYTE0   = 4'b0001;
    localparam logic [LANES-1:0] BE_HALF_LO = 4'b0011;
    localparam logic [LANES-1:0] BE_HALF_HI = 4'b1100;
    localparam logic [LANES-1:0] BE_WORD    = 4'b1111;

    // An access is misaligned when its address is not a multiple of its size.
    function automatic logic access_misaligned(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        logic mis;
        case (mem_size_e'(size))
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = addr_lo[0];
            default:   mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/core_mem_lane.sv
// core_mem_lane: byte-lane steering for stores and lane extraction/extension for loads.
module core_mem_lane
    import core_mem_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] st_data,
    input  logic [DATA_W-1:0] ld_word,
    output logic [LANES-1:0]  be,
    output logic [DATA_W-1:0] st_lanes,
    output logic [DATA_W-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: enables follow the address, data is replicated so every enabled lane sees it
    always_comb begin
        be       = BE_WORD;
        st_lanes = st_data;
        case (mem_size_e'(size))
            SIZE_BYTE: begin
                be       = BE_BYTE0 << addr_lo;
                st_lanes = {4{st_data[7:0]}};
            end
            SIZE_HALF: begin
                be       = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                st_lanes = {2{st_data[15:0]}};
            end
            default: begin
                be       = BE_WORD;
                st_lanes = st_data;
            end
        endcase
    end

    // Load side: pick the addressed lane, then zero- or sign-extend to a full word
    always_comb begin
        case (addr_lo)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (mem_size_e'(size))
            SIZE_BYTE: ld_data = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
            SIZE_HALF: ld_data = {{16{~is_unsigned & ld_half[15]}}, ld_half};
            default:   ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/core_mem_access.sv
// core_mem_access: MEM-stage load/store sequencer. Legal accesses are captured,
// issued on the request channel and completed with a single-cycle valid pulse;
// misaligned accesses and ALU-only instructions complete in the same cycle.
module core_mem_access
    import core_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] read_memdata,
    output logic              v_read_memdata,
    output logic              mem_err,
    output logic              stall,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [LANES-1:0]  m_be,
    input  logic              m_ack,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata
);

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              op_valid;
    logic              op_misaligned;
    logic [LANES-1:0]  lane_be;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_ldata;

    assign op_valid      = mem_read | mem_write;
    assign op_misaligned = access_misaligned(mem_size, addr[1:0]);

    // Lane logic works from the captured access so outputs stay stable while stalled
    core_mem_lane u_lane (
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .is_unsigned (uns_q),
        .st_data     (wdata_q),
        .ld_word     (rdata_q),
        .be          (lane_be),
        .st_lanes    (lane_wdata),
        .ld_data     (lane_ldata)
    );

    // State register: reset drops any in-flight access back to IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured access fields and read response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state and capture decisions
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (op_valid && !op_misaligned) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    size_d  = mem_size;
                    uns_d   = mem_unsigned;
                    // A simultaneous read and write is executed as a load.
                    we_d    = mem_write & ~mem_read;
                    rdata_d = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (m_ack) begin
                    if (we_q) begin
                        state_d = ST_DONE;
                    end else if (m_rvalid) begin
                        rdata_d = m_rdata;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (m_rvalid) begin
                    rdata_d = m_rdata;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // The pipeline advances on this edge, so never re-issue from here.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from state and the current MEM-stage instruction
    always_comb begin
        read_memdata   = '0;
        v_read_memdata = 1'b0;
        mem_err        = 1'b0;
        stall          = 1'b0;
        m_req          = 1'b0;
        m_we           = 1'b0;
        m_addr         = '0;
        m_wdata        = '0;
        m_be           = '0;
        case (state_q)
            ST_IDLE: begin
                if (!op_valid) begin
                    v_read_memdata = 1'b1;
                end else if (op_misaligned) begin
                    v_read_memdata = 1'b1;
                    // Error flag is held low while reset is asserted.
                    mem_err        = rst;
                end else begin
                    stall = 1'b1;
                end
            end
            ST_REQ: begin
                stall   = 1'b1;
                m_req   = 1'b1;
                m_we    = we_q;
                m_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                m_wdata = lane_wdata;
                m_be    = lane_be;
            end
            ST_WAIT: begin
                stall = 1'b1;
            end
            ST_DONE: begin
                v_read_memdata = 1'b1;
                read_memdata   = we_q ? '0 : lane_ldata;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_core_mem_access.sv
// tb_core_mem_access: directed vectors, hand sequences and randomized accesses
// for the MEM-stage load/store unit.
module tb_core_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata;
    logic [31:0] read_memdata;
    logic        v_read_memdata, mem_err, stall;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        m_ack, m_rvalid;
    logic [31:0] m_rdata;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] a;
        logic [31:0] wd;
        int          ack_dly;
        int          rv_dly;
        logic [31:0] rword;
        logic        err;
        logic        we;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic [31:0] rdat;
    } vec_t;

    vec_t vecs[14];

    core_mem_access dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_size       (mem_size),
        .mem_unsigned   (mem_unsigned),
        .addr           (addr),
        .wdata          (wdata),
        .read_memdata   (read_memdata),
        .v_read_memdata (v_read_memdata),
        .mem_err        (mem_err),
        .stall          (stall),
        .m_req          (m_req),
        .m_we           (m_we),
        .m_addr         (m_addr),
        .m_wdata        (m_wdata),
        .m_be           (m_be),
        .m_ack          (m_ack),
        .m_rvalid       (m_rvalid),
        .m_rdata        (m_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_bytes(input logic [1:0] sz);
        if (sz == 2'd0) return 1;
        if (sz == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
        return (int'(a[1:0]) % ref_bytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
        int n;
        int lane;
        n = ref_bytes(sz);
        lane = int'(a[1:0]);
        return 4'(((1 << n) - 1) << lane);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] wd);
        int n;
        n = ref_bytes(sz);
        if (n == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [31:0] a,
                                             input logic un, input logic [31:0] word);
        int n;
        logic [31:0] v;
        logic [31:0] span;
        n = ref_bytes(sz);
        if (n == 4) return word;
        span = 32'(1) << (8 * n);
        v = (word >> (8 * int'(a[1:0]))) & (span - 1);
        if (!un && v >= (span >> 1)) v = v - span;
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Each helper starts just after a rising edge and ends just after the next one.
    task automatic alu_cycle(input int id);
        mem_read = 1'b0; mem_write = 1'b0;
        mem_size = 2'($urandom); mem_unsigned = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        m_ack = 1'($urandom); m_rvalid = 1'($urandom); m_rdata = $urandom;
        #2;
        chk1($sformatf("alu_v[%0d]", id), v_read_memdata, 1'b1);
        chk1($sformatf("alu_stall[%0d]", id), stall, 1'b0);
        chk1($sformatf("alu_mreq[%0d]", id), m_req, 1'b0);
        chk1($sformatf("alu_err[%0d]", id), mem_err, 1'b0);
        chk32($sformatf("alu_rdata[%0d]", id), read_memdata, 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic run_op(input vec_t v, input int id);
        mem_read = v.rd; mem_write = v.wr; mem_size = v.sz; mem_unsigned = v.un;
        addr = v.a; wdata = v.wd;
        m_ack = 1'b0; m_rvalid = 1'($urandom); m_rdata = $urandom;
        #2;
        if (v.err) begin
            chk1($sformatf("mis_v[%0d]", id), v_read_memdata, 1'b1);
            chk1($sformatf("mis_err[%0d]", id), mem_err, 1'b1);
            chk32($sformatf("mis_rdata[%0d]", id), read_memdata, 32'h0);
            chk1($sformatf("mis_stall[%0d]", id), stall, 1'b0);
            chk1($sformatf("mis_mreq[%0d]", id), m_req, 1'b0);
            @(posedge clk); #1;
            m_rvalid = 1'b0;
            return;
        end
        chk1($sformatf("op_v[%0d]", id), v_read_memdata, 1'b0);
        chk1($sformatf("op_stall[%0d]", id), stall, 1'b1);
        chk1($sformatf("op_mreq[%0d]", id), m_req, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i <= v.ack_dly; i++) begin
            m_ack = (i == v.ack_dly);
            if (m_ack) begin
                m_rvalid = !v.we && (v.rv_dly == 0);
                m_rdata  = m_rvalid ? v.rword : $urandom;
            end else begin
                m_rvalid = 1'($urandom);
                m_rdata  = $urandom;
            end
            #2;
            chk1($sformatf("req_mreq[%0d]", id), m_req, 1'b1);
            chk1($sformatf("req_we[%0d]", id), m_we, v.we);
            chk32($sformatf("req_addr[%0d]", id), m_addr, {v.a[31:2], 2'b00});
            chk32($sformatf("req_be[%0d]", id), {28'h0, m_be}, {28'h0, v.be});
            chk32($sformatf("req_wdata[%0d]", id), m_wdata, v.mwd);
            chk1($sformatf("req_stall[%0d]", id), stall, 1'b1);
            chk1($sformatf("req_v[%0d]", id), v_read_memdata, 1'b0);
            @(posedge clk); #1;
        end
        m_ack = 1'b0; m_rvalid = 1'b0;
        if (!v.we && v.rv_dly > 0) begin
            for (int i = 1; i <= v.rv_dly; i++) begin
                m_rvalid = (i == v.rv_dly);
                m_rdata  = m_rvalid ? v.rword : $urandom;
                #2;
                chk1($sformatf("wait_mreq[%0d]", id), m_req, 1'b0);
                chk1($sformatf("wait_stall[%0d]", id), stall, 1'b1);
                chk1($sformatf("wait_v[%0d]", id), v_read_memdata, 1'b0);
                @(posedge clk); #1;
            end
        end
        m_ack = 1'b0; m_rvalid = 1'($urandom); m_rdata = $urandom;
        #2;
        chk1($sformatf("done_v[%0d]", id), v_read_memdata, 1'b1);
        chk1($sformatf("done_stall[%0d]", id), stall, 1'b0);
        chk1($sformatf("done_err[%0d]", id), mem_err, 1'b0);
        chk1($sformatf("done_mreq[%0d]", id), m_req, 1'b0);
        chk32($sformatf("done_rdata[%0d]", id), read_memdata, v.rdat);
        @(posedge clk); #1;
        m_rvalid = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t rv;
        int   n;
        int   kind;

        // rd wr sz un addr wdata ackd rvd rword | err we be mwd rdat
        vecs[0]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        2, 3, 32'hDEADBEEF,
                     1'b0, 1'b0, 4'hF, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        0, 0, 32'h8000_0000,
                     1'b0, 1'b0, 4'h8, 32'h0,        32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        0, 0, 32'h8000_0000,
                     1'b0, 1'b0, 4'h8, 32'h0,        32'h0000_0080};
        vecs[3]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h1234,     0, 0, 32'h0,
                     1'b0, 1'b1, 4'hC, 32'h1234_1234, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0,        0, 0, 32'h0,
                     1'b1, 1'b0, 4'h0, 32'h0,        32'h0};
        vecs[5]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h203, 32'h0,        0, 0, 32'h0,
                     1'b1, 1'b0, 4'h0, 32'h0,        32'h0};
        vecs[6]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h202, 32'h0,        1, 2, 32'h8001_7FFF,
                     1'b0, 1'b0, 4'hC, 32'h0,        32'hFFFF_8001};
        vecs[7]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h200, 32'h0,        0, 0, 32'h1234_F00D,
                     1'b0, 1'b0, 4'h3, 32'h0,        32'h0000_F00D};
        vecs[8]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h301, 32'hA5,       1, 0, 32'h0,
                     1'b0, 1'b1, 4'h2, 32'hA5A5_A5A5, 32'h0};
        vecs[9]  = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h400, 32'h1111_1111, 0, 1, 32'hCAFE_F00D,
                     1'b0, 1'b0, 4'hF, 32'h1111_1111, 32'hCAFE_F00D};
        vecs[10] = '{1'b0, 1'b1, 2'd3, 1'b0, 32'h404, 32'h89AB_CDEF, 0, 0, 32'h0,
                     1'b0, 1'b1, 4'hF, 32'h89AB_CDEF, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 2'd3, 1'b0, 32'h406, 32'h0,        0, 0, 32'h0,
                     1'b1, 1'b1, 4'h0, 32'h0,        32'h0};
        vecs[12] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0,        0, 0, 32'h0000_7F00,
                     1'b0, 1'b0, 4'h2, 32'h0,        32'h0000_007F};
        vecs[13] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h003, 32'hFFFF_FF3C, 2, 0, 32'h0,
                     1'b0, 1'b1, 4'h8, 32'h3C3C_3C3C, 32'h0};

        // Reset state, with a misaligned load sitting on the inputs
        rst = 1'b0;
        mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'd2; mem_unsigned = 1'b0;
        addr = 32'h101; wdata = 32'h0;
        m_ack = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #3;
        chk1("rst_mreq", m_req, 1'b0);
        chk1("rst_mwe", m_we, 1'b0);
        chk32("rst_mbe", {28'h0, m_be}, 32'h0);
        chk1("rst_err", mem_err, 1'b0);
        chk32("rst_rdata", read_memdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        mem_read = 1'b0;

        // ALU-only instructions pass straight through
        for (int i = 0; i < 5; i++) alu_cycle(i);

        // Directed vectors
        for (int i = 0; i < 14; i++) run_op(vecs[i], i);

        // Reset while waiting for a read response, then a stale response arrives
        mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'd2; mem_unsigned = 1'b0;
        addr = 32'h500; wdata = 32'h0; m_ack = 1'b0; m_rvalid = 1'b0;
        #2;
        chk1("rw_op_stall", stall, 1'b1);
        @(posedge clk); #1;
        m_ack = 1'b1;
        #2;
        chk1("rw_req_mreq", m_req, 1'b1);
        @(posedge clk); #1;
        m_ack = 1'b0;
        #2;
        chk1("rw_wait_mreq", m_req, 1'b0);
        chk1("rw_wait_stall", stall, 1'b1);
        #2;
        rst = 1'b0;
        mem_read = 1'b0;
        #1;
        chk1("rw_inrst_mreq", m_req, 1'b0);
        chk1("rw_inrst_stall", stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        m_rvalid = 1'b1; m_rdata = 32'hBAD0_BAD0;
        #2;
        chk1("rw_stale_v", v_read_memdata, 1'b1);
        chk1("rw_stale_stall", stall, 1'b0);
        chk1("rw_stale_mreq", m_req, 1'b0);
        chk32("rw_stale_rdata", read_memdata, 32'h0);
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        run_op(vecs[0], 50);

        // Randomized accesses against the reference model
        for (int k = 0; k < 40; k++) begin
            kind      = $urandom_range(0, 2);
            rv.rd     = (kind != 1);
            rv.wr     = (kind != 0);
            rv.sz     = 2'($urandom_range(0, 3));
            rv.un     = 1'($urandom_range(0, 1));
            rv.a      = $urandom;
            n         = ref_bytes(rv.sz);
            if ($urandom_range(0, 3) != 0) rv.a = rv.a & ~(32'(n) - 32'd1);
            rv.wd      = $urandom;
            rv.ack_dly = $urandom_range(0, 3);
            rv.rv_dly  = $urandom_range(0, 3);
            rv.rword   = $urandom;
            rv.err     = ref_misaligned(rv.sz, rv.a);
            rv.we      = rv.wr && !rv.rd;
            rv.be      = ref_be(rv.sz, rv.a);
            rv.mwd     = ref_wdata(rv.sz, rv.wd);
            rv.rdat    = rv.we ? 32'h0 : ref_load(rv.sz, rv.a, rv.un, rv.rword);
            run_op(rv, 100 + k);
            if ($urandom_range(0, 2) == 0) alu_cycle(200 + k);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
